axis_eth_fcs_wide: RTL and testbench

Parametrised AXI4-Stream Ethernet FCS generator/checker for datapaths of 8 to 64 bits. It computes the IEEE 802.3 CRC-32 over each frame using `tkeep` for the partial last beat, and reports per frame the FCS, the frame byte length and an error flag. The block sits as a passive tap beside the MAC TX/RX datapath, with `tready` always high. It succeeds the byte-wide FCS generator for wide MAC interfaces.

---
 rtl/axis_eth_fcs_wide_pkg.sv | 31 +++
 rtl/axis_eth_fcs_wide_lfsr.sv | 23 ++
 rtl/axis_eth_fcs_wide.sv | 150 +++++++++++++++
 tb/tb_axis_eth_fcs_wide.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_eth_fcs_wide_pkg.sv
// Shared CRC-32 constants and the byte-serial reflected CRC step for the wide FCS tap.
// Used by both builds; the residue constant only matters with AXIS_ETH_FCS_WIDE_CHECK_EN.
package axis_eth_fcs_wide_pkg;

  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [15:0] LEN_SAT     = 16'hFFFF;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  localparam logic [31:0] CRC_POLY_REFL = reflect32(CRC_POLY);

  // Bit 0 of each byte is first on the wire, so the register shifts right.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'd0, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/axis_eth_fcs_wide_lfsr.sv
// Combinational CRC-32 advance over BYTES bytes of data_in, byte 0 first.
module axis_eth_fcs_wide_lfsr
  import axis_eth_fcs_wide_pkg::*;
#(
  parameter int BYTES = 1
) (
  input  logic [31:0]        state_in,
  input  logic [8*BYTES-1:0] data_in,
  output logic [31:0]        next_state
);

  logic [31:0] crc_next;

  always_comb begin
    crc_next = state_in;
    for (int i = 0; i < BYTES; i++) begin
      crc_next = crc32_byte(crc_next, data_in[8*i +: 8]);
    end
  end

  assign next_state = crc_next;

endmodule

// File: rtl/axis_eth_fcs_wide.sv
// AXI4-Stream Ethernet FCS generator/checker tap (8..64-bit datapath); reports FCS, length, error.
// Optional residue check with output_fcs_ok enabled by AXIS_ETH_FCS_WIDE_CHECK_EN.
module axis_eth_fcs_wide
  import axis_eth_fcs_wide_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic [31:0]           output_fcs,
  output logic                  output_fcs_valid,
  output logic [15:0]           output_frame_len,
  output logic                  output_bad_frame
`ifdef AXIS_ETH_FCS_WIDE_CHECK_EN
  ,
  output logic                  output_fcs_ok
`endif
);

  localparam int CW = $clog2(KEEP_WIDTH + 1);

  logic [31:0] crc_state_reg, crc_state_next;
  logic [15:0] len_cnt_reg, len_cnt_next;
  logic        bad_acc_reg, bad_acc_next;
  logic [31:0] fcs_reg, fcs_next;
  logic        fcs_valid_reg, fcs_valid_next;
  logic [15:0] frame_len_reg, frame_len_next;
  logic        bad_frame_reg, bad_frame_next;

  logic [CW-1:0] keep_cnt;
  logic [CW-1:0] byte_cnt;
  logic [31:0]   crc_folded;
  logic [16:0]   len_sum;
  logic [15:0]   len_sat;
  logic [31:0]   lfsr_out [1:KEEP_WIDTH];

  // One advance unit per possible byte count, all fed from the same state.
  for (genvar gi = 1; gi <= KEEP_WIDTH; gi++) begin : g_lfsr
    axis_eth_fcs_wide_lfsr #(
      .BYTES(gi)
    ) u_lfsr (
      .state_in  (crc_state_reg),
      .data_in   (s_axis_tdata[8*gi-1:0]),
      .next_state(lfsr_out[gi])
    );
  end

  always_comb begin
    keep_cnt = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      keep_cnt = keep_cnt + CW'(s_axis_tkeep[i]);
    end
  end

  // tkeep only qualifies the last beat; earlier beats are always full width.
  assign byte_cnt = s_axis_tlast ? keep_cnt : CW'(KEEP_WIDTH);

  always_comb begin
    crc_folded = crc_state_reg;
    for (int i = 1; i <= KEEP_WIDTH; i++) begin
      if (byte_cnt == CW'(i)) begin
        crc_folded = lfsr_out[i];
      end
    end
  end

  assign len_sum = {1'b0, len_cnt_reg} + 17'(byte_cnt);
  assign len_sat = len_sum[16] ? LEN_SAT : len_sum[15:0];

  always_comb begin
    crc_state_next = crc_state_reg;
    len_cnt_next   = len_cnt_reg;
    bad_acc_next   = bad_acc_reg;
    fcs_next       = fcs_reg;
    fcs_valid_next = 1'b0;
    frame_len_next = frame_len_reg;
    bad_frame_next = bad_frame_reg;
    if (s_axis_tvalid) begin
      if (s_axis_tlast) begin
        fcs_next       = ~crc_folded;
        fcs_valid_next = 1'b1;
        frame_len_next = len_sat;
        bad_frame_next = bad_acc_reg | s_axis_tuser;
        crc_state_next = CRC_INIT;
        len_cnt_next   = '0;
        bad_acc_next   = 1'b0;
      end else begin
        crc_state_next = crc_folded;
        len_cnt_next   = len_sat;
        bad_acc_next   = bad_acc_reg | s_axis_tuser;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_state_reg <= CRC_INIT;
      len_cnt_reg   <= '0;
      bad_acc_reg   <= 1'b0;
      fcs_reg       <= '0;
      fcs_valid_reg <= 1'b0;
      frame_len_reg <= '0;
      bad_frame_reg <= 1'b0;
    end else begin
      crc_state_reg <= crc_state_next;
      len_cnt_reg   <= len_cnt_next;
      bad_acc_reg   <= bad_acc_next;
      fcs_reg       <= fcs_next;
      fcs_valid_reg <= fcs_valid_next;
      frame_len_reg <= frame_len_next;
      bad_frame_reg <= bad_frame_next;
    end
  end

`ifdef AXIS_ETH_FCS_WIDE_CHECK_EN
  logic fcs_ok_reg, fcs_ok_next;

  // A frame carrying its own valid FCS leaves the fixed residue in the raw CRC state.
  always_comb begin
    fcs_ok_next = fcs_ok_reg;
    if (s_axis_tvalid && s_axis_tlast) begin
      fcs_ok_next = (crc_folded == CRC_RESIDUE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fcs_ok_reg <= 1'b0;
    end else begin
      fcs_ok_reg <= fcs_ok_next;
    end
  end

  assign output_fcs_ok = fcs_ok_reg;
`endif

  assign s_axis_tready    = 1'b1;
  assign output_fcs       = fcs_reg;
  assign output_fcs_valid = fcs_valid_reg;
  assign output_frame_len = frame_len_reg;
  assign output_bad_frame = bad_frame_reg;

endmodule

// File: tb/tb_axis_eth_fcs_wide.sv
// Scoreboard bench for axis_eth_fcs_wide at 64-bit width; reference CRC computed MSB-first on reflected bytes.
module tb_axis_eth_fcs_wide;

  localparam int DW = 64;
  localparam int KW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] tdata;
  logic [KW-1:0] tkeep;
  logic          tvalid, tlast, tuser;
  logic          tready;
  logic [31:0]   fcs;
  logic          fcs_valid;
  logic [15:0]   frame_len;
  logic          bad_frame;
`ifdef AXIS_ETH_FCS_WIDE_CHECK_EN
  logic          fcs_ok;
`endif

  axis_eth_fcs_wide #(.DATA_WIDTH(DW)) dut (
    .clk             (clk),
    .rst             (rst),
    .s_axis_tdata    (tdata),
    .s_axis_tkeep    (tkeep),
    .s_axis_tvalid   (tvalid),
    .s_axis_tready   (tready),
    .s_axis_tlast    (tlast),
    .s_axis_tuser    (tuser),
    .output_fcs      (fcs),
    .output_fcs_valid(fcs_valid),
    .output_frame_len(frame_len),
    .output_bad_frame(bad_frame)
`ifdef AXIS_ETH_FCS_WIDE_CHECK_EN
    ,
    .output_fcs_ok   (fcs_ok)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] fcs;
    logic [15:0] len;
    logic        bad;
    logic        ok;
  } exp_t;

  exp_t     sb[$];
  time      pulse_times[$];
  int       total = 0;
  int       bad_cnt = 0;
  int       frame_no = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Non-reflected MSB-first CRC on bit-reversed input; result reflected back to the wire-order state.
  function automatic logic [31:0] ref_state(input logic [7:0] d[$], input int n);
    logic [31:0] c;
    logic [31:0] r;
    logic        fb;
    c = 32'hFFFFFFFF;
    for (int j = 0; j < n; j++) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[31] ^ d[j][b];
        c  = {c[30:0], 1'b0};
        if (fb) c = c ^ 32'h04C11DB7;
      end
    end
    for (int i = 0; i < 32; i++) r[i] = c[31-i];
    return r;
  endfunction

  function automatic exp_t model(input logic [7:0] d[$], input logic bad);
    exp_t e;
    int   n;
    n     = d.size();
    e.fcs = ~ref_state(d, n);
    e.len = (n > 65535) ? 16'hFFFF : 16'(n);
    e.bad = bad;
    e.ok  = (n >= 4) && ({d[n-1], d[n-2], d[n-3], d[n-4]} == ~ref_state(d, n - 4));
    return e;
  endfunction

  // Monitor: pops one expectation per valid pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (fcs_valid) begin
        pulse_times.push_back($time);
        if (sb.size() == 0) begin
          total++;
          bad_cnt++;
          $display("FAIL unexpected_pulse: got fcs %h expected no pulse", fcs);
        end else begin
          e = sb.pop_front();
          frame_no++;
          $display("frame %0d: fcs=%h len=%0d bad=%0b", frame_no, fcs, frame_len, bad_frame);
          check("fcs", fcs, e.fcs);
          check("frame_len", {16'd0, frame_len}, {16'd0, e.len});
          check("bad_frame", {31'd0, bad_frame}, {31'd0, e.bad});
`ifdef AXIS_ETH_FCS_WIDE_CHECK_EN
          check("fcs_ok", {31'd0, fcs_ok}, {31'd0, e.ok});
`endif
        end
      end
    end
  end

  task automatic send_frame(input logic [7:0] d[$], input int user_mode, input int gap_pct,
                            input bit empty_last);
    int          n, beats, idx;
    bit          eff_empty;
    logic        bad_f;
    logic [KW-1:0] keep_l;
    n         = d.size();
    eff_empty = empty_last && (n % KW == 0);
    beats     = (n + KW - 1) / KW + (eff_empty ? 1 : 0);
    bad_f     = 1'b0;
    for (int b = 0; b < beats; b++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        tvalid = 1'b0;
        tdata  = {$urandom, $urandom};
        tlast  = $urandom_range(1);
        @(posedge clk);
        #1;
      end
      for (int k = 0; k < KW; k++) begin
        idx             = b * KW + k;
        tdata[8*k +: 8] = (idx < n) ? d[idx] : 8'($urandom);
        keep_l[k]       = (idx < n);
      end
      tlast = (b == beats - 1);
      tkeep = tlast ? keep_l : KW'($urandom);
      case (user_mode)
        1:       tuser = (b == 0);
        2:       tuser = ($urandom_range(9) == 0);
        default: tuser = 1'b0;
      endcase
      bad_f  = bad_f | tuser;
      tvalid = 1'b1;
      if (tlast) sb.push_back(model(d, bad_f));
      @(posedge clk);
      #1;
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    tuser  = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      total++;
      bad_cnt++;
      $display("FAIL timeout: got %0d pending frames expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] kat[$];
    logic [7:0] d[$];
    int         np;
    kat = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    rst = 1'b1; tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; tkeep = '0; tdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_fcs", fcs, 32'h0);
    check("reset_len", {16'd0, frame_len}, 32'd0);
    check("reset_bad", {31'd0, bad_frame}, 32'd0);
    check("reset_valid", {31'd0, fcs_valid}, 32'd0);
    check("tready", {31'd0, tready}, 32'd1);
`ifdef AXIS_ETH_FCS_WIDE_CHECK_EN
    check("reset_ok", {31'd0, fcs_ok}, 32'd0);
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Known answer with partial last beat
    send_frame(kat, 0, 0, 0);
    wait_idle();
    check("kat_fcs", fcs, 32'hCBF43926);
    check("kat_len", {16'd0, frame_len}, 32'd9);

    // Back-to-back frames
    np = pulse_times.size();
    send_frame(kat, 0, 0, 0);
    send_frame(kat, 0, 0, 0);
    wait_idle();
    check("b2b_pulses", pulse_times.size() - np, 2);
    if (pulse_times.size() - np == 2)
      check("b2b_spacing", 32'(pulse_times[np+1] - pulse_times[np]), 32'd20);

    // Error flag on first beat, then clean frame
    d.delete();
    for (int i = 0; i < 3 * KW; i++) d.push_back(8'($urandom));
    send_frame(d, 1, 0, 0);
    send_frame(d, 0, 0, 0);
    wait_idle();
    check("clean_after_bad", {31'd0, bad_frame}, 32'd0);

    // Empty last beat adds nothing
    d = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38};
    send_frame(d, 0, 0, 1);
    wait_idle();
    check("empty_last_len", {16'd0, frame_len}, 32'd8);

    // Reset mid-frame then gapped frame
    np = pulse_times.size();
    tvalid = 1'b1; tlast = 1'b0; tkeep = '1; tdata = {$urandom, $urandom};
    @(posedge clk); #1;
    tdata = {$urandom, $urandom};
    @(posedge clk); #1;
    tvalid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_fcs", fcs, 32'h0);
    check("midrst_len", {16'd0, frame_len}, 32'd0);
    send_frame(kat, 0, 40, 0);
    wait_idle();
    check("midrst_pulses", pulse_times.size() - np, 1);
    check("midrst_kat", fcs, 32'hCBF43926);
    check("midrst_len9", {16'd0, frame_len}, 32'd9);

    // Randomised frames
    for (int f = 0; f < 30; f++) begin
      d.delete();
      for (int i = $urandom_range(200, 1); i > 0; i--) d.push_back(8'($urandom));
      send_frame(d, 2, $urandom_range(3) == 0 ? 30 : 0, $urandom_range(1));
    end
    wait_idle();

`ifdef AXIS_ETH_FCS_WIDE_CHECK_EN
    d = kat;
    d.push_back(8'h26); d.push_back(8'h39); d.push_back(8'hF4); d.push_back(8'hCB);
    send_frame(d, 0, 0, 0);
    wait_idle();
    check("check_good", {31'd0, fcs_ok}, 32'd1);
    d[4] = 8'h36;
    send_frame(d, 0, 0, 0);
    wait_idle();
    check("check_bad", {31'd0, fcs_ok}, 32'd0);
`endif

    // Length saturation
    d.delete();
    for (int i = 0; i < 65540; i++) d.push_back(8'($urandom));
    send_frame(d, 0, 0, 0);
    wait_idle();
    check("sat_len", {16'd0, frame_len}, 32'h0000FFFF);

    $display("test done: total=%0d bad=%0d", total, bad_cnt);
    $finish;
  end

endmodule
